divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 16 +
 rtl/divider_step.sv | 28 ++
 rtl/divider.sv | 125 ++++++++++++
 tb/tb_divider.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared arithmetic definitions: the common FSM state encoding used by the
// multi-cycle arithmetic blocks, plus a sizing helper for their bit counters.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPUTING = 2'd1,
    ST_DONE      = 2'd2
  } arith_state_t;

  // Counter width needed to index every bit of a 2*width-bit operand.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// Single restoring-division step: shift the partial remainder left, bring in
// the next dividend bit, and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // Compare and subtract one bit wider than the divisor so a divisor with its
  // MSB set never loses the carry. A set top bit of the incoming remainder
  // means the shifted value exceeds any divisor, so it forces a subtraction.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], dividend_bit};
    fits     = rem[WIDTH] | (shifted >= {1'b0, divisor});
    diff     = shifted - {1'b0, divisor};
    q_bit    = fits;
    rem_next = fits ? diff : shifted;
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per cycle, MSB first. A zero divisor skips the
// iteration and reports all-ones quotient with the low dividend bits as
// remainder.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [2*WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0]   divisor_in,
  input  logic               valid_in,
  output logic [2*WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0]   remainder_out,
  output logic               valid_out,
  output logic               busy_out,
  output logic               div_zero_out
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

  arith_state_t state_q, state_d;
  logic         accept;
  logic         done;

  logic [2*WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [WIDTH:0]     rem_q;
  logic [2*WIDTH-1:0] quo_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     step_rem;
  logic               step_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem          (rem_q),
    .dividend_bit (dividend_q[cnt_q]),
    .divisor      (divisor_q),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  // State register; reset wins over any start request on the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A zero divisor is detected on the latched copy in the
  // first cycle after acceptance and goes straight to DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          accept  = 1'b1;
          state_d = ST_COMPUTING;
        end
      end
      ST_COMPUTING: begin
        if ((divisor_q == '0) || (cnt_q == '0)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at accept, then one restoring step per COMPUTING cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      dividend_q <= dividend_in;
      divisor_q  <= divisor_in;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= CNT_LAST;
    end else if ((state_q == ST_COMPUTING) && (divisor_q != '0)) begin
      rem_q <= step_rem;
      quo_q <= {quo_q[2*WIDTH-2:0], step_q};
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Result registers: loaded only when leaving DONE, held until the next one.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out     <= 1'b0;
      div_zero_out  <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else begin
      valid_out <= done;
      if (done) begin
        if (divisor_q == '0) begin
          quotient_out  <= '1;
          remainder_out <= dividend_q[WIDTH-1:0];
          div_zero_out  <= 1'b1;
        end else begin
          quotient_out  <= quo_q;
          remainder_out <= rem_q[WIDTH-1:0];
          div_zero_out  <= 1'b0;
        end
      end
    end
  end

  // Busy covers the whole operation including the result pulse.
  assign busy_out = (state_q != ST_IDLE) | valid_out;

endmodule

// File: tb/tb_divider.sv
// Bench for the restoring divider: directed corner cases plus random operands,
// scored against plain integer division through an expectation queue.
module tb_divider;

  localparam int W  = 256;
  localparam int DW = 2 * W;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          valid_in;
  logic [DW-1:0] dividend_in;
  logic [W-1:0]  divisor_in;
  logic [DW-1:0] quotient_out;
  logic [W-1:0]  remainder_out;
  logic          valid_out;
  logic          busy_out;
  logic          div_zero_out;

  typedef struct {
    logic [DW-1:0] q;
    logic [W-1:0]  r;
    logic          dz;
    int            edge_at;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   edge_cnt  = 0;
  int   free_edge = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  divider #(.WIDTH(W)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .valid_in      (valid_in),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out),
    .div_zero_out  (div_zero_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, DW'(act), DW'(exp));
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  // Reference: floor division and modulo, with the zero-divisor convention.
  function automatic exp_t model(input logic [DW-1:0] dd, input logic [W-1:0] dv, input int acc);
    exp_t          e;
    logic [DW-1:0] dv_w;
    logic [DW-1:0] rem_w;
    if (dv == '0) begin
      e.q       = '1;
      e.r       = dd[W-1:0];
      e.dz      = 1'b1;
      e.edge_at = acc + 2;
    end else begin
      dv_w      = DW'(dv);
      e.q       = dd / dv_w;
      rem_w     = dd % dv_w;
      e.r       = rem_w[W-1:0];
      e.dz      = 1'b0;
      e.edge_at = acc + DW + 1;
    end
    return e;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (valid_out) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_out=1 at edge %0d expected no result", edge_cnt);
      end else begin
        m_e = sb_q.pop_front();
        check("quotient", quotient_out, m_e.q);
        check("remainder", DW'(remainder_out), DW'(m_e.r));
        check("div_zero", DW'(div_zero_out), DW'(m_e.dz));
        check("valid_edge", DW'(edge_cnt), DW'(m_e.edge_at));
      end
    end
  end

  task automatic wait_until(input int target);
    while (edge_cnt < target) @(negedge clk_in);
  endtask

  // Start one operation at the earliest edge the DUT can accept it.
  task automatic issue(input logic [DW-1:0] dd, input logic [W-1:0] dv,
                       input bit toggle, output int acc);
    @(negedge clk_in);
    while (edge_cnt + 1 < free_edge) @(negedge clk_in);
    dividend_in = dd;
    divisor_in  = dv;
    valid_in    = 1'b1;
    acc         = edge_cnt + 1;
    sb_q.push_back(model(dd, dv, acc));
    free_edge   = acc + ((dv == '0) ? 3 : DW + 2);
    @(negedge clk_in);
    valid_in = 1'b0;
    if (toggle) begin
      while (edge_cnt < free_edge) begin
        dividend_in = rand_wide();
        divisor_in  = W'(rand_wide());
        @(negedge clk_in);
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got time limit expired expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acc;
    int            mode;
    int            t;
    logic [DW-1:0] dd;
    logic [W-1:0]  dv;

    rst_in      = 1'b1;
    valid_in    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(negedge clk_in);
    check1("reset_valid", valid_out, 1'b0);
    check1("reset_busy", busy_out, 1'b0);
    check1("reset_div_zero", div_zero_out, 1'b0);
    check("reset_quotient", quotient_out, '0);
    check("reset_remainder", DW'(remainder_out), '0);
    rst_in    = 1'b0;
    free_edge = edge_cnt + 1;

    // 1000 / 7 with busy and single-cycle pulse checks around completion
    issue(DW'(1000), W'(7), 1'b0, acc);
    check1("busy_after_accept", busy_out, 1'b1);
    wait_until(acc + DW);
    check1("valid_not_early", valid_out, 1'b0);
    check1("busy_mid_op", busy_out, 1'b1);
    wait_until(acc + DW + 1);
    check1("busy_with_valid", busy_out, 1'b1);
    wait_until(acc + DW + 2);
    check1("valid_one_cycle", valid_out, 1'b0);
    check1("busy_after_done", busy_out, 1'b0);

    // 2^511 + 5 divided by 2^255
    dd = '0;
    dd[DW-1] = 1'b1;
    dd = dd + DW'(5);
    dv = '0;
    dv[W-1] = 1'b1;
    issue(dd, dv, 1'b0, acc);

    // Divide by zero
    issue(DW'(12345), W'(0), 1'b0, acc);
    check1("dz_busy", busy_out, 1'b1);

    // Dividend below an all-ones divisor, operands scrambled while busy
    dv = '1;
    issue(DW'(3), dv, 1'b1, acc);

    // Start pulse during COMPUTING must be ignored
    issue(rand_wide(), W'(12345678), 1'b0, acc);
    wait_until(acc + 50);
    valid_in    = 1'b1;
    dividend_in = rand_wide();
    divisor_in  = W'(5);
    @(negedge clk_in);
    valid_in = 1'b0;

    // Random operands across magnitude classes
    for (int k = 0; k < 20; k++) begin
      dd   = rand_wide() >> $urandom_range(0, DW - 1);
      mode = $urandom_range(0, 9);
      if (mode == 0) dv = '0;
      else if (mode < 4) dv = W'($urandom_range(1, 1000));
      else if (mode < 7) begin
        dv = W'(rand_wide());
        dv[W-1] = 1'b1;
      end else begin
        dv = W'(rand_wide() >> $urandom_range(0, DW - 1));
        if (dv == '0) dv = W'(1);
      end
      issue(dd, dv, 1'b0, acc);
    end

    // valid_in held high: back-to-back operations
    @(negedge clk_in);
    while (edge_cnt + 1 < free_edge) @(negedge clk_in);
    valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      while (edge_cnt + 1 < free_edge) begin
        @(negedge clk_in);
        dividend_in = rand_wide();
      end
      dd = rand_wide();
      dv = W'(rand_wide() >> $urandom_range(0, W));
      if (dv == '0) dv = W'(3);
      dividend_in = dd;
      divisor_in  = dv;
      acc         = edge_cnt + 1;
      sb_q.push_back(model(dd, dv, acc));
      free_edge   = acc + DW + 2;
      @(negedge clk_in);
    end
    valid_in = 1'b0;

    // Reset 100 cycles into an operation aborts it
    issue(rand_wide(), W'(987654321), 1'b0, acc);
    wait_until(acc + 99);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    void'(sb_q.pop_back());
    check1("abort_busy", busy_out, 1'b0);
    check1("abort_valid", valid_out, 1'b0);
    free_edge = edge_cnt + 1;
    repeat (DW + 90) @(negedge clk_in);

    // Reset and start on the same edge: reset wins
    rst_in      = 1'b1;
    valid_in    = 1'b1;
    dividend_in = DW'(77);
    divisor_in  = W'(5);
    @(negedge clk_in);
    rst_in   = 1'b0;
    valid_in = 1'b0;
    check1("rst_over_valid_busy", busy_out, 1'b0);
    free_edge = edge_cnt + 1;

    // Fresh operation after the abort: 100 / 9
    issue(DW'(100), W'(9), 1'b0, acc);

    t = 0;
    while (sb_q.size() != 0 && t < DW + 20) begin
      @(negedge clk_in);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
